out_port_display: RTL

//  Downstream consumer of the processor's WB-stage output (outW/resultW/haltW).
//  - Captures each OUT word into a small FIFO.
//  - Shows each word in turn on a 4-digit multiplexed 7-seg display, holding it HOLD_CYCLES.
//  - Reports overflow drops and a sticky halt indication.
//  The processor has no backpressure input, so words arriving while the FIFO is full are dropped and counted.

---
 rtl/out_port_display_pkg.sv | 37 +++
 rtl/out_port_display_sync_fifo.sv | 41 ++++
 rtl/out_port_display.sv | 125 ++++++++++++
 3 files changed

// File: rtl/out_port_display_pkg.sv
// Shared definitions for the OUT-port display: FSM encodings, drop ceiling
// and the active-low hex to 7-segment decode.
package out_port_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } dispState_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Active-low, bit order gfedcba.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] segs;
    case (nib)
      4'h0:    segs = 7'b1000000;
      4'h1:    segs = 7'b1111001;
      4'h2:    segs = 7'b0100100;
      4'h3:    segs = 7'b0110000;
      4'h4:    segs = 7'b0011001;
      4'h5:    segs = 7'b0010010;
      4'h6:    segs = 7'b0000010;
      4'h7:    segs = 7'b1111000;
      4'h8:    segs = 7'b0000000;
      4'h9:    segs = 7'b0010000;
      4'hA:    segs = 7'b0001000;
      4'hB:    segs = 7'b0000011;
      4'hC:    segs = 7'b1000110;
      4'hD:    segs = 7'b0100001;
      4'hE:    segs = 7'b0000110;
      default: segs = 7'b0001110;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/out_port_display_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is presented on dout
// while not empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= din;
  end

  assign dout  = mem[rdPtr[AW-1:0]];
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

endmodule

// File: rtl/out_port_display.sv
// Captures processor OUT words into a FIFO and shows each one in turn on a
// 4-digit multiplexed 7-segment display; tracks overflow drops and halt.
//
// state | meaning
// IDLE  | queue empty, last word stays on the display
// LOAD  | pop queue head into the display register, arm hold timer
// HOLD  | hold timer running down; next word or IDLE at terminal count
module out_port_display
  import out_port_display_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SCAN_DIV    = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        out_valid,
  input  logic [15:0] out_data,
  input  logic        halt_in,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        fifo_full,
  output logic        halted,
  output logic [7:0]  drop_cnt
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  dispState_t        state;
  dispState_t        stateNext;
  logic [HOLD_W-1:0] holdCnt;
  logic              holdDone;
  logic [15:0]       dispWord;
  logic [15:0]       fifoDout;
  logic              fifoEmpty;
  logic              popEn;
  logic              pushEn;
  logic              dropEn;
  logic [SCAN_W-1:0] scanCnt;
  logic [1:0]        digit;
  logic [3:0]        nibble;

  // A full FIFO still accepts a word in the cycle the FSM pops it.
  assign pushEn = out_valid && !halted && (!fifo_full || popEn);
  assign dropEn = out_valid && !halted && fifo_full && !popEn;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushEn),
    .pop   (popEn),
    .din   (out_data),
    .dout  (fifoDout),
    .full  (fifo_full),
    .empty (fifoEmpty)
  );

  // Exit at 1 rather than 0 so the LOAD cycle counts towards the hold time.
  assign holdDone = (holdCnt <= HOLD_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    popEn     = 1'b0;
    case (state)
      IDLE: if (!fifoEmpty) stateNext = LOAD;
      LOAD: begin
        popEn     = !fifoEmpty;
        stateNext = HOLD;
      end
      HOLD: if (holdDone) stateNext = fifoEmpty ? IDLE : LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holdCnt  <= '0;
      dispWord <= '0;
    end else begin
      if (state == LOAD) holdCnt <= HOLD_LOAD;
      else if (state == HOLD && holdCnt != '0) holdCnt <= holdCnt - HOLD_W'(1);
      if (popEn) dispWord <= fifoDout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (halt_in) halted <= 1'b1;
      if (dropEn && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scanCnt <= '0;
      digit   <= 2'd0;
    end else if (scanCnt == SCAN_LAST) begin
      scanCnt <= '0;
      digit   <= digit + 2'd1;
    end else begin
      scanCnt <= scanCnt + SCAN_W'(1);
    end
  end

  always_comb begin
    nibble = dispWord[4*digit +: 4];
    an     = ~(4'b0001 << digit);
    seg    = {~(digit == 2'd0 && halted), hex7seg(nibble)};
  end

endmodule
